// File: rtl/product_accumulator_pkg.sv
// Shared types and default sizing for the product accumulator stage that sits
// behind the 4x4 array multiplier.
package product_acc_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_e;

    localparam int DEF_PROD_W    = 8;
    localparam int DEF_ACC_W     = 12;
    localparam int DEF_BLOCK_LEN = 16;

endpackage

// File: rtl/product_accumulator_if.sv
// Input and output valid/ready channels of the product accumulator.
// The master drives products and consumes block totals; the slave is the accumulator.
interface product_accumulator_if
    import product_acc_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W
);
    logic              in_valid;
    logic              in_ready;
    logic [PROD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [ACC_W-1:0]  out_data;
    logic              out_sat;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );

endinterface

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned saturating adder: the sum is formed one bit wider than the operands
// and clamps to all ones when the carry bit is set.
module sat_adder #(
    parameter int ACC_W = 12
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             overflow
);
    logic [ACC_W:0] w_wide;

    assign w_wide   = {1'b0, a} + {1'b0, b};
    assign overflow = w_wide[ACC_W];
    assign sum      = w_wide[ACC_W] ? {ACC_W{1'b1}} : w_wide[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Sums blocks of BLOCK_LEN unsigned products into a saturating accumulator and
// hands each block total, with a sticky saturation flag, to the downstream consumer.
module product_accumulator
    import product_acc_pkg::*;
#(
    parameter int PROD_W    = DEF_PROD_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int BLOCK_LEN = DEF_BLOCK_LEN,
    parameter int CNT_W     = $clog2(BLOCK_LEN)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 clear,
    product_accumulator_if.slave bus,
    output logic [CNT_W-1:0]     count
);
    localparam logic [0:0]       ST_ACCUM = ACCUM;
    localparam logic [0:0]       ST_DONE  = DONE;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

    logic [0:0]       r_state;
    logic [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic             r_sat;
    logic             r_out_valid;
    logic [ACC_W-1:0] r_out_data;
    logic             r_out_sat;

    logic             w_in_ready;
    logic             w_accept;
    logic             w_last;
    logic [ACC_W-1:0] w_sum;
    logic             w_overflow;

    // Ready depends only on registered state and the tile enable, never on in_valid.
    assign w_in_ready = (r_state == ST_ACCUM) && ena;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_last     = (r_count == LAST_CNT);

    sat_adder #(
        .ACC_W(ACC_W)
    ) u_sat_adder (
        .a        (r_acc),
        .b        (ACC_W'(bus.in_data)),
        .sum      (w_sum),
        .overflow (w_overflow)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sat   <= 1'b0;
        end else if (clear) begin
            // Abort drops any pending result and any handshake on this edge.
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_count     <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (ena) begin
            case (r_state)
                ST_ACCUM: begin
                    if (w_accept) begin
                        if (w_last) begin
                            r_out_data  <= w_sum;
                            r_out_sat   <= r_sat | w_overflow;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                            r_acc       <= '0;
                            r_count     <= '0;
                            r_sat       <= 1'b0;
                        end else begin
                            r_acc   <= w_sum;
                            r_count <= r_count + CNT_W'(1);
                            r_sat   <= r_sat | w_overflow;
                        end
                    end
                end
                ST_DONE: begin
                    if (r_out_valid && bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_ACCUM;
                    end
                end
                default: r_state <= ST_ACCUM;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sat   = r_out_sat;
    assign count         = r_count;

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator: block totals go through a scoreboard
// queue checked by an output monitor; control and boundary behaviour is checked inline.
module tb_product_accumulator;
    import product_acc_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ena   = 1'b0;
    logic clear = 1'b0;
    logic sclear = 1'b0;
    logic [3:0] count;
    logic [3:0] scount;

    always #5 clk = ~clk;

    product_accumulator_if #(.PROD_W(8), .ACC_W(12)) bus ();
    product_accumulator_if #(.PROD_W(8), .ACC_W(10)) sbus ();

    product_accumulator #(.PROD_W(8), .ACC_W(12), .BLOCK_LEN(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (clear),
        .bus   (bus.slave),
        .count (count)
    );

    product_accumulator #(.PROD_W(8), .ACC_W(10), .BLOCK_LEN(16)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .ena   (ena),
        .clear (sclear),
        .bus   (sbus.slave),
        .count (scount)
    );

    typedef struct {
        logic [11:0] data;
        logic        sat;
    } exp_t;

    exp_t q[$];
    exp_t sq[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %0d (t=%0t)", name, act, $time);
        end
    endtask

    // Result monitor for the default-size instance.
    logic seen = 1'b0;
    exp_t cur;
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got %0d, expected none", bus.out_data);
                    cur.data = bus.out_data;
                    cur.sat  = bus.out_sat;
                end else begin
                    cur = q.pop_front();
                    check("result_data", 32'(bus.out_data), 32'(cur.data));
                    check("result_sat", 32'(bus.out_sat), 32'(cur.sat));
                end
            end else begin
                check("result_hold", 32'(bus.out_data), 32'(cur.data));
            end
        end else begin
            seen = 1'b0;
        end
    end

    // Result monitor for the narrow-accumulator instance.
    logic sseen = 1'b0;
    exp_t scur;
    always @(negedge clk) begin
        if (rst_n && sbus.out_valid) begin
            if (!sseen) begin
                sseen = 1'b1;
                if (sq.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_sat_result: got %0d, expected none", sbus.out_data);
                    scur.data = 12'(sbus.out_data);
                    scur.sat  = sbus.out_sat;
                end else begin
                    scur = sq.pop_front();
                    check("sat_result_data", 32'(sbus.out_data), 32'(scur.data));
                    check("sat_result_flag", 32'(sbus.out_sat), 32'(scur.sat));
                end
            end
        end else begin
            sseen = 1'b0;
        end
    end

    task automatic send(input logic [7:0] v);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
    endtask

    task automatic ssend(input logic [7:0] v);
        @(negedge clk);
        sbus.in_valid = 1'b1;
        sbus.in_data  = v;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        sbus.in_valid = 1'b0;
    endtask

    function automatic exp_t mk(input int d, input bit s);
        exp_t e;
        e.data = 12'(d);
        e.sat  = s;
        return e;
    endfunction

    initial begin
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b1;
        sbus.in_valid  = 1'b0;
        sbus.in_data   = '0;
        sbus.out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_count", 32'(count), 0);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_sat", 32'(bus.out_sat), 0);
        check("rst_in_ready_ena0", 32'(bus.in_ready), 0);
        ena = 1'b1;
        #1;
        check("rst_in_ready_ena1", 32'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Full block, no backpressure: 16 x 225
        q.push_back(mk(3600, 1'b0));
        for (int i = 0; i < 16; i++) begin
            send(8'd225);
            if (i == 9) check("t1_count_mid", 32'(count), 9);
        end
        idle();
        check("t1_out_valid_up", 32'(bus.out_valid), 1);
        check("t1_in_ready_done", 32'(bus.in_ready), 0);
        @(negedge clk);
        check("t1_out_valid_one_cycle", 32'(bus.out_valid), 0);
        check("t1_in_ready_back", 32'(bus.in_ready), 1);

        // Backpressure: products 1..16, consumer stalls, in_valid pulses in DONE
        bus.out_ready = 1'b0;
        q.push_back(mk(136, 1'b0));
        for (int i = 1; i <= 16; i++) send(8'(i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd99;
            #1;
            check("t2_in_ready_low", 32'(bus.in_ready), 0);
            check("t2_out_valid_held", 32'(bus.out_valid), 1);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        idle();
        check("t2_released", 32'(bus.out_valid), 0);
        check("t2_count_clean", 32'(count), 0);
        q.push_back(mk(64, 1'b0));
        for (int i = 0; i < 16; i++) send(8'd4);
        idle();
        @(negedge clk);

        // Clear mid-block, with a concurrent product that must be ignored
        for (int i = 0; i < 7; i++) send(8'd50);
        @(negedge clk);
        check("t3_count_before_clear", 32'(count), 7);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd50;
        @(negedge clk);
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("t3_count_after_clear", 32'(count), 0);
        q.push_back(mk(32, 1'b0));
        for (int i = 0; i < 16; i++) send(8'd2);
        idle();
        @(negedge clk);

        // Clear while holding a result
        bus.out_ready = 1'b0;
        q.push_back(mk(160, 1'b0));
        for (int i = 0; i < 16; i++) send(8'd10);
        idle();
        check("t3b_done_valid", 32'(bus.out_valid), 1);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        check("t3b_valid_dropped", 32'(bus.out_valid), 0);
        check("t3b_count_zero", 32'(count), 0);
        check("t3b_in_ready", 32'(bus.in_ready), 1);
        bus.out_ready = 1'b1;

        // Asynchronous reset between edges at count = 9
        for (int i = 0; i < 9; i++) send(8'd7);
        idle();
        check("t4_count_pre_reset", 32'(count), 9);
        #2;
        rst_n = 1'b0;
        #1;
        check("t4_async_count", 32'(count), 0);
        check("t4_async_out_data", 32'(bus.out_data), 0);
        check("t4_async_out_valid", 32'(bus.out_valid), 0);
        check("t4_async_out_sat", 32'(bus.out_sat), 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.push_back(mk(48, 1'b0));
        for (int i = 0; i < 16; i++) send(8'd3);
        idle();
        @(negedge clk);

        // Enable gap of 3 cycles with in_valid held
        q.push_back(mk(96, 1'b0));
        for (int i = 0; i < 5; i++) send(8'd6);
        for (int g = 0; g < 3; g++) begin
            @(negedge clk);
            ena          = 1'b0;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd6;
            #1;
            check("t5_count_frozen", 32'(count), 5);
            check("t5_in_ready_gated", 32'(bus.in_ready), 0);
        end
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            ena          = 1'b1;
            bus.in_valid = 1'b1;
            bus.in_data  = 8'd6;
        end
        idle();
        @(negedge clk);

        // Saturation on the 10-bit instance, then a clean block
        sq.push_back(mk(1023, 1'b1));
        for (int i = 0; i < 16; i++) ssend(8'd100);
        idle();
        @(negedge clk);
        sq.push_back(mk(16, 1'b0));
        for (int i = 0; i < 16; i++) ssend(8'd1);
        idle();

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(q.size()), 0);
        check("sat_scoreboard_drained", 32'(sq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
